baser_257b_lock_monitor: RTL and testbench

//  Parametrised receive-side monitor for 257b transcoded BASE-R blocks; replaces the fixed-stream 257b checker.

---
 rtl/baser_257b_lock_monitor_if.sv | 11 +
 rtl/baser_257b_lock_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_baser_257b_lock_monitor.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baser_257b_lock_monitor_if.sv
// Transcoded block stream: one valid qualifier plus the full transcoded block.
// The monitor reads its input through the slave view and drives its copy through the master view.
interface baser_257b_lock_monitor_if #(
  parameter int TC_WIDTH = 257
) ();
  logic                valid;
  logic [TC_WIDTH-1:0] xcoded;

  modport master (output valid, output xcoded);
  modport slave  (input  valid, input  xcoded);
endinterface

// File: rtl/baser_257b_lock_monitor.sv
// Receive-side monitor for 257b transcoded BASE-R blocks: sync-header lock with slip request,
// windowed hi-BER and saturating statistics. Define BASER_MON_PATTERN_CHECK_EN for the data-pattern counter.
module baser_257b_lock_monitor #(
  parameter int         TRANSCODER_BLOCKS = 4,
  parameter int         LOCK_GOOD_CNT     = 64,
  parameter int         LOCK_BAD_CNT      = 16,
  parameter int         BER_WINDOW        = 1024,
  parameter int         BER_THRESH        = 97,
  parameter int         COUNT_WIDTH       = 32,
  parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  baser_257b_lock_monitor_if.slave  i_rx,
  baser_257b_lock_monitor_if.master o_tx,
  input  logic                   i_clear_cnt,
  output logic                   o_block_lock,
  output logic                   o_slip,
  output logic                   o_hi_ber,
  output logic [COUNT_WIDTH-1:0] o_block_count,
  output logic [COUNT_WIDTH-1:0] o_data_count,
  output logic [COUNT_WIDTH-1:0] o_ctrl_count,
  output logic [COUNT_WIDTH-1:0] o_inv_sh_count,
  output logic [COUNT_WIDTH-1:0] o_slip_count,
  output logic [COUNT_WIDTH-1:0] o_inv_pattern_count
);
  localparam int TC_WIDTH = 64 * TRANSCODER_BLOCKS + 1;
  localparam int SH_W     = $clog2(LOCK_GOOD_CNT + 1);
  localparam int WIN_W    = $clog2(BER_WINDOW + 1);
  localparam int BER_W    = $clog2(BER_THRESH + 1);
  localparam logic [SH_W-1:0]  SH_GOOD = SH_W'(LOCK_GOOD_CNT);
  localparam logic [SH_W-1:0]  SH_BAD  = SH_W'(LOCK_BAD_CNT);
  localparam logic [WIN_W-1:0] WIN_END = WIN_W'(BER_WINDOW);
  localparam logic [BER_W-1:0] BER_MAX = BER_W'(BER_THRESH);

  typedef enum logic [1:0] {RESET_CNT = 2'd0, TEST_SH = 2'd1, SLIP = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [SH_W-1:0]     r_sh_cnt, r_bad_cnt, w_sh_nxt, w_bad_nxt;
  logic [SH_W-1:0]     w_sh_base, w_bad_base, w_sh_inc, w_bad_inc;
  logic [WIN_W-1:0]    r_win_cnt, w_win_nxt, w_win_inc;
  logic [BER_W-1:0]    r_ber_cnt, w_ber_nxt, w_ber_inc;
  logic                w_lock_nxt, w_slip_nxt, w_slip_cond, w_hiber_nxt;
  logic                w_hdr_inv;
  logic [TC_WIDTH-1:0] w_blk;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign w_blk     = i_rx.xcoded;
  // A control block whose flags claim every sub-block is data carries no control and is illegal.
  assign w_hdr_inv = (w_blk[0] == 1'b0) && (w_blk[TRANSCODER_BLOCKS:1] == '1);

  // Lock FSM next state: RESET_CNT and SLIP both start a fresh window on the current block.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_lock_nxt  = o_block_lock;
    w_slip_nxt  = 1'b0;
    w_sh_base   = r_sh_cnt;
    w_bad_base  = r_bad_cnt;
    case (r_state)
      TEST_SH: begin
        w_sh_base  = r_sh_cnt;
        w_bad_base = r_bad_cnt;
      end
      RESET_CNT, SLIP: begin
        w_sh_base  = '0;
        w_bad_base = '0;
      end
      default: begin
        w_sh_base  = '0;
        w_bad_base = '0;
      end
    endcase
    w_sh_inc    = w_sh_base + 1'b1;
    w_bad_inc   = w_bad_base + w_hdr_inv;
    w_slip_cond = o_block_lock ? (w_bad_inc == SH_BAD) : w_hdr_inv;
    if (i_rx.valid) begin
      if (w_slip_cond) begin
        w_state_nxt = SLIP;
        w_sh_nxt    = '0;
        w_bad_nxt   = '0;
        w_lock_nxt  = 1'b0;
        w_slip_nxt  = 1'b1;
      end else if (w_sh_inc == SH_GOOD) begin
        w_state_nxt = RESET_CNT;
        w_sh_nxt    = '0;
        w_bad_nxt   = '0;
        w_lock_nxt  = o_block_lock | (w_bad_inc == '0);
      end else begin
        w_state_nxt = TEST_SH;
        w_sh_nxt    = w_sh_inc;
        w_bad_nxt   = w_bad_inc;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Hi-BER window: only runs on blocks seen while already locked; losing lock wipes it.
  always_comb begin
    w_win_nxt   = r_win_cnt;
    w_ber_nxt   = r_ber_cnt;
    w_hiber_nxt = o_hi_ber;
    w_win_inc   = r_win_cnt + 1'b1;
    w_ber_inc   = (w_hdr_inv && (r_ber_cnt != BER_MAX)) ? r_ber_cnt + 1'b1 : r_ber_cnt;
    if (!w_lock_nxt) begin
      w_win_nxt   = '0;
      w_ber_nxt   = '0;
      w_hiber_nxt = 1'b0;
    end else if (i_rx.valid && o_block_lock) begin
      if (w_win_inc == WIN_END) begin
        w_win_nxt   = '0;
        w_ber_nxt   = '0;
        w_hiber_nxt = (w_ber_inc == BER_MAX);
      end else begin
        w_win_nxt   = w_win_inc;
        w_ber_nxt   = w_ber_inc;
        w_hiber_nxt = o_hi_ber | (w_ber_inc == BER_MAX);
      end
    end else begin
      w_win_nxt   = r_win_cnt;
      w_ber_nxt   = r_ber_cnt;
      w_hiber_nxt = o_hi_ber;
    end
  end

  // State, lock/BER registers and the registered stream copy.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RESET_CNT;
      r_sh_cnt     <= '0;
      r_bad_cnt    <= '0;
      r_win_cnt    <= '0;
      r_ber_cnt    <= '0;
      o_block_lock <= 1'b0;
      o_slip       <= 1'b0;
      o_hi_ber     <= 1'b0;
      o_tx.valid   <= 1'b0;
      o_tx.xcoded  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sh_cnt     <= w_sh_nxt;
      r_bad_cnt    <= w_bad_nxt;
      r_win_cnt    <= w_win_nxt;
      r_ber_cnt    <= w_ber_nxt;
      o_block_lock <= w_lock_nxt;
      o_slip       <= w_slip_nxt;
      o_hi_ber     <= w_hiber_nxt;
      o_tx.valid   <= i_rx.valid;
      if (i_rx.valid) begin
        o_tx.xcoded <= w_blk;
      end
    end
  end

  // Statistics: saturate at all-ones; the clear takes priority over any increment.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_block_count  <= '0;
      o_data_count   <= '0;
      o_ctrl_count   <= '0;
      o_inv_sh_count <= '0;
      o_slip_count   <= '0;
    end else if (i_clear_cnt) begin
      o_block_count  <= '0;
      o_data_count   <= '0;
      o_ctrl_count   <= '0;
      o_inv_sh_count <= '0;
      o_slip_count   <= '0;
    end else begin
      o_block_count  <= sat_inc(o_block_count,  i_rx.valid);
      o_data_count   <= sat_inc(o_data_count,   i_rx.valid && w_blk[0]);
      o_ctrl_count   <= sat_inc(o_ctrl_count,   i_rx.valid && !w_blk[0] && !w_hdr_inv);
      o_inv_sh_count <= sat_inc(o_inv_sh_count, i_rx.valid && w_hdr_inv);
      o_slip_count   <= sat_inc(o_slip_count,   w_slip_nxt);
    end
  end

`ifdef BASER_MON_PATTERN_CHECK_EN
  localparam logic [TC_WIDTH-2:0] DATA_PATTERN = {(TRANSCODER_BLOCKS * 8){DATA_CHAR_PATTERN}};
  logic w_pat_bad;
  assign w_pat_bad = i_rx.valid && w_blk[0] && (w_blk[TC_WIDTH-1:1] != DATA_PATTERN);

  // All-data blocks whose payload differs from the expected idle/data character.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inv_pattern_count <= '0;
    end else if (i_clear_cnt) begin
      o_inv_pattern_count <= '0;
    end else begin
      o_inv_pattern_count <= sat_inc(o_inv_pattern_count, w_pat_bad);
    end
  end
`else
  assign o_inv_pattern_count = '0;
`endif

endmodule

// File: tb/tb_baser_257b_lock_monitor.sv
// Self-checking bench for baser_257b_lock_monitor: directed table, corner sequences and a
// randomized run against a window-based reference model; a second instance uses COUNT_WIDTH=4.
module tb_baser_257b_lock_monitor;
  localparam int TCW   = 257;
  localparam int LGOOD = 64;
  localparam int LBAD  = 16;
  localparam int BWIN  = 1024;
  localparam int BTH   = 97;
`ifdef BASER_MON_PATTERN_CHECK_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  always #5 clk = ~clk;

  baser_257b_lock_monitor_if #(.TC_WIDTH(TCW)) rx_if ();
  baser_257b_lock_monitor_if #(.TC_WIDTH(TCW)) tx_if ();
  baser_257b_lock_monitor_if #(.TC_WIDTH(TCW)) tx2_if ();

  logic        lock1, slip1, hiber1, lock2, slip2, hiber2;
  logic [31:0] c1 [6];
  logic [3:0]  c2 [6];

  baser_257b_lock_monitor dut (
    .clk(clk), .i_rst_n(rst_n), .i_rx(rx_if), .o_tx(tx_if), .i_clear_cnt(clear),
    .o_block_lock(lock1), .o_slip(slip1), .o_hi_ber(hiber1),
    .o_block_count(c1[0]), .o_data_count(c1[1]), .o_ctrl_count(c1[2]),
    .o_inv_sh_count(c1[3]), .o_slip_count(c1[4]), .o_inv_pattern_count(c1[5])
  );

  baser_257b_lock_monitor #(.COUNT_WIDTH(4)) dut_small (
    .clk(clk), .i_rst_n(rst_n), .i_rx(rx_if), .o_tx(tx2_if), .i_clear_cnt(clear),
    .o_block_lock(lock2), .o_slip(slip2), .o_hi_ber(hiber2),
    .o_block_count(c2[0]), .o_data_count(c2[1]), .o_ctrl_count(c2[2]),
    .o_inv_sh_count(c2[3]), .o_slip_count(c2[4]), .o_inv_pattern_count(c2[5])
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit slip_seen;
  string cnt_name [6] = '{"block_count", "data_count", "ctrl_count", "inv_sh_count", "slip_count", "inv_pattern_count"};

  // Reference model: lock judged on a list of header outcomes since the window started.
  bit           m_lock, m_slip, m_hiber, m_v;
  logic [TCW-1:0] m_x;
  bit           m_win [$];
  int           m_ber_blocks, m_ber_bad;
  longint       m_stat [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint cap);
    return (v > cap) ? cap : v;
  endfunction

  function automatic logic [TCW-1:0] mk(input bit hdr, input logic [3:0] flags, input logic [7:0] byt);
    logic [TCW-1:0] x;
    x = {{32{byt}}, hdr};
    if (!hdr) x[4:1] = flags;
    return x;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_slip = 0; m_hiber = 0; m_v = 0; m_x = '0;
    m_win.delete();
    m_ber_blocks = 0; m_ber_bad = 0;
    for (int k = 0; k < 6; k++) m_stat[k] = 0;
  endtask

  task automatic model_block(input bit v, input logic [TCW-1:0] x, input bit clr);
    bit inv, pre, pat_bad;
    int bad;
    logic [255:0] good_pl;
    good_pl = {32{8'hAA}};
    inv     = (x[0] == 1'b0) && (x[4:1] == 4'hF);
    pat_bad = PAT_EN && x[0] && (x[256:1] != good_pl);
    m_slip  = 0;
    if (v) begin
      pre = m_lock;
      m_win.push_back(inv);
      bad = 0;
      foreach (m_win[i]) bad += int'(m_win[i]);
      if (pre ? (bad >= LBAD) : inv) begin
        m_lock = 0; m_slip = 1; m_win.delete();
      end else if (m_win.size() == LGOOD) begin
        if (bad == 0) m_lock = 1;
        m_win.delete();
      end
      if (!m_lock) begin
        m_ber_blocks = 0; m_ber_bad = 0; m_hiber = 0;
      end else if (pre) begin
        m_ber_blocks++;
        if (inv && m_ber_bad < BTH) m_ber_bad++;
        if (m_ber_bad == BTH) m_hiber = 1;
        if (m_ber_blocks == BWIN) begin
          if (m_ber_bad < BTH) m_hiber = 0;
          m_ber_blocks = 0; m_ber_bad = 0;
        end
      end
      m_v = 1; m_x = x;
      m_stat[0]++;
      if (x[0]) m_stat[1]++;
      if (!x[0] && !inv) m_stat[2]++;
      if (inv) m_stat[3]++;
      if (m_slip) m_stat[4]++;
      if (pat_bad) m_stat[5]++;
    end else begin
      m_v = 0;
    end
    if (clr) for (int k = 0; k < 6; k++) m_stat[k] = 0;
  endtask

  task automatic compare_all();
    chk("o_valid", tx_if.valid, m_v);
    if (m_v) begin
      n_checks++;
      if (tx_if.xcoded !== m_x) begin
        n_fail++;
        $display("FAIL o_rx_xcoded actual=%h required=%h", tx_if.xcoded, m_x);
      end
    end
    chk("o_block_lock", lock1, m_lock);
    chk("o_slip", slip1, m_slip);
    chk("o_hi_ber", hiber1, m_hiber);
    chk("small_o_block_lock", lock2, m_lock);
    chk("small_o_valid", tx2_if.valid, m_v);
    for (int k = 0; k < 6; k++) begin
      chk(cnt_name[k], c1[k], sat(m_stat[k], 64'hFFFF_FFFF));
      chk({"small_", cnt_name[k]}, c2[k], sat(m_stat[k], 64'd15));
    end
  endtask

  task automatic step(input bit v, input logic [TCW-1:0] x, input bit clr);
    @(negedge clk);
    rx_if.valid  = v;
    rx_if.xcoded = x;
    clear        = clr;
    model_block(v, x, clr);
    @(posedge clk);
    #1;
    compare_all();
    slip_seen = slip_seen | slip1;
    rx_if.valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_if.valid = 1'b0;
    clear       = 1'b0;
    rst_n       = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    slip_seen = 1'b0;
  endtask

  typedef struct {
    bit v; bit hdr; logic [3:0] flags; bit clr;
    int e_blk; int e_ctrl; int e_inv; int e_slipc; bit e_slip;
  } vec_t;
  vec_t tbl [8];

  logic [TCW-1:0] clean_blk, bad_blk;

  initial begin
    tbl[0] = '{1, 0, 4'h3, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{0, 1, 4'h0, 0, 1, 1, 0, 0, 0};
    tbl[2] = '{1, 1, 4'h0, 0, 2, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 4'hF, 0, 3, 1, 1, 1, 1};
    tbl[4] = '{0, 1, 4'h0, 0, 3, 1, 1, 1, 0};
    tbl[5] = '{1, 1, 4'h0, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 4'hE, 0, 1, 1, 0, 0, 0};
    tbl[7] = '{1, 0, 4'hF, 0, 2, 1, 1, 1, 1};
    clean_blk    = mk(1'b1, 4'h0, 8'hAA);
    bad_blk      = mk(1'b0, 4'hF, 8'hAA);
    rst_n        = 1'b0;
    clear        = 1'b0;
    rx_if.valid  = 1'b0;
    rx_if.xcoded = '0;
    model_reset();

    // Directed table from reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, mk(tbl[i].hdr, tbl[i].flags, 8'hAA), tbl[i].clr);
      chk("tbl_block_count", c1[0], tbl[i].e_blk);
      chk("tbl_ctrl_count", c1[2], tbl[i].e_ctrl);
      chk("tbl_inv_sh_count", c1[3], tbl[i].e_inv);
      chk("tbl_slip_count", c1[4], tbl[i].e_slipc);
      chk("tbl_slip", slip1, tbl[i].e_slip);
    end

    // 64 clean blocks give lock one cycle after the last
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, clean_blk, 1'b0);
      if (i == 62) chk("A_lock_early", lock1, 0);
    end
    chk("A_lock", lock1, 1);
    chk("A_data_count", c1[1], 64);
    chk("A_no_slip", slip_seen, 0);

    // Unlocked invalid header at block 10, then 64 clean blocks to relock
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, (i == 9) ? bad_blk : clean_blk, 1'b0);
    chk("B_slip", slip1, 1);
    chk("B_slip_count", c1[4], 1);
    for (int j = 0; j < 64; j++) begin
      step(1'b1, clean_blk, 1'b0);
      if (j == 0)  chk("B_slip_one_cycle", slip1, 0);
      if (j == 62) chk("B_lock_early", lock1, 0);
    end
    chk("B_relock", lock1, 1);

    // Locked: 16 invalid headers in one window lose lock
    for (int i = 0; i < 16; i++) begin
      step(1'b1, bad_blk, 1'b0);
      if (i == 14) chk("C_lock_held", lock1, 1);
    end
    chk("C_lock_lost", lock1, 0);
    chk("C_slip", slip1, 1);
    chk("C_hi_ber", hiber1, 0);

    // Relock, then 97 invalid headers spread over one BER window
    for (int i = 0; i < 64; i++) step(1'b1, clean_blk, 1'b0);
    chk("D_relock", lock1, 1);
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, ((i % 10) == 9) ? bad_blk : clean_blk, 1'b0);
      if (i == 968) chk("D_hi_ber_early", hiber1, 0);
      if (i == 969) chk("D_hi_ber_set", hiber1, 1);
    end
    chk("D_lock_kept", lock1, 1);
    for (int j = 0; j < 1024; j++) begin
      step(1'b1, clean_blk, 1'b0);
      if (j == 1022) chk("D_hi_ber_held", hiber1, 1);
    end
    chk("D_hi_ber_cleared", hiber1, 0);

    // Clear coinciding with a valid block
    step(1'b1, clean_blk, 1'b1);
    chk("E_block_count", c1[0], 0);
    chk("E_data_count", c1[1], 0);
    chk("E_slip_count", c1[4], 0);
    chk("E_lock", lock1, 1);

    // Narrow counters saturate; mismatching payload feeds the pattern counter
    for (int i = 0; i < 20; i++) step(1'b1, mk(1'b1, 4'h0, 8'h55), 1'b0);
    chk("F_small_block_count", c2[0], 15);
    chk("F_small_data_count", c2[1], 15);
    chk("F_small_pattern", c2[5], PAT_EN ? 15 : 0);
    chk("F_wide_block_count", c1[0], 20);

    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      bit v, hdr, clr;
      logic [3:0] fl;
      logic [7:0] byt;
      if (i == 1500) do_reset();
      v   = ($urandom % 4) != 0;
      clr = ($urandom % 150) == 0;
      byt = (($urandom % 4) == 0) ? 8'($urandom) : 8'hAA;
      if (($urandom % 60) == 0) begin
        hdr = 1'b0; fl = 4'hF;
      end else begin
        hdr = 1'($urandom);
        fl  = 4'($urandom);
        if (!hdr && fl == 4'hF) fl = 4'h7;
      end
      step(v, mk(hdr, fl, byt), clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
